johnson_phase_sched: RTL and testbench

Run controller for the 4-stage Johnson ring counter. It owns the ring register, and on a start request it sequences the ring through a programmed number of full revolutions. While running it emits one-hot phase strobes and a remaining-revolution count, and it pulses `done` at completion. Downstream logic uses the strobes for multi-phase timing, such as stepper or scan sequencing, instead of a free-running counter.

---
 rtl/johnson_phase_sched.sv | 120 ++++++++++++
 tb/tb_johnson_phase_sched.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_sched.sv
// johnson_phase_sched: run controller for a WIDTH-stage Johnson ring counter.
// Sequences the ring through a captured number of full revolutions on i_start.
// It emits one-hot phase strobes and a remaining-revolution count, and pulses done or aborted.
// Ports:
//   i_clk, i_reset (async, active-high).
//   i_start / i_rotations : run request and revolution count, sampled in IDLE.
//   i_hold / i_abort      : freeze / terminate, only honoured in RUN (abort > hold).
//   o_busy / o_done / o_aborted : RUN level, DONE pulse, post-abort pulse.
//   o_ring / o_phase / o_remaining : ring value, one-hot phase (RUN only), revolutions left.
module johnson_phase_sched #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [CNT_W-1:0]   i_rotations,
  input  logic               i_hold,
  input  logic               i_abort,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_aborted,
  output logic [WIDTH-1:0]   o_ring,
  output logic [2*WIDTH-1:0] o_phase,
  output logic [CNT_W-1:0]   o_remaining
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Final code of a revolution: only the last stage set (1000 for WIDTH=4).
  localparam logic [WIDTH-1:0] LAST_CODE = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_ring;
  logic [CNT_W-1:0] r_remaining;
  logic             r_aborted;

  logic [WIDTH-1:0] w_ring_next;
  logic             w_step;
  logic             w_wrap;
  logic             w_last;

  assign w_ring_next = {r_ring[WIDTH-2:0], ~r_ring[WIDTH-1]};
  assign w_step      = (r_state == S_RUN) && !i_abort && !i_hold;
  // A revolution completes on the step out of the last code back to all-zero.
  assign w_wrap      = w_step && (r_ring == LAST_CODE);
  assign w_last      = w_wrap && (r_remaining == CNT_W'(1));

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_next = (i_rotations != '0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        if (i_abort)     w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Ring, revolution count and abort pulse
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ring      <= '0;
      r_remaining <= '0;
      r_aborted   <= 1'b0;
    end else begin
      r_aborted <= (r_state == S_RUN) && i_abort;
      case (r_state)
        S_IDLE: begin
          if (i_start && (i_rotations != '0)) begin
            r_ring      <= '0;
            r_remaining <= i_rotations;
          end
        end
        S_RUN: begin
          if (i_abort) begin
            r_ring      <= '0;
            r_remaining <= '0;
          end else if (!i_hold) begin
            r_ring <= w_ring_next;
            // remaining is >= 1 throughout RUN, so this cannot underflow.
            if (w_wrap) r_remaining <= r_remaining - CNT_W'(1);
          end
        end
        default: r_ring <= '0;
      endcase
    end
  end

  // Output logic: phase index k is the k-th code of the Johnson sequence, so
  // walk the sequence from all-zero and flag the matching position.
  always_comb begin
    logic [WIDTH-1:0] w_code;
    o_busy  = (r_state == S_RUN);
    o_done  = (r_state == S_DONE);
    o_phase = '0;
    w_code  = '0;
    for (int k = 0; k < 2*WIDTH; k++) begin
      if ((r_state == S_RUN) && (r_ring == w_code)) o_phase[k] = 1'b1;
      w_code = {w_code[WIDTH-2:0], ~w_code[WIDTH-1]};
    end
  end

  assign o_ring      = r_ring;
  assign o_remaining = r_remaining;
  assign o_aborted   = r_aborted;

endmodule

// File: tb/tb_johnson_phase_sched.sv
// Directed bench for johnson_phase_sched (WIDTH=4, CNT_W=8).
// Stimulus pushes expected outputs keyed by cycle number; a negedge monitor
// pops and compares them, independently of the stimulus process.
module tb_johnson_phase_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] rotations = 8'd0;
  logic       hold = 1'b0;
  logic       abort = 1'b0;
  logic       busy, done, aborted;
  logic [3:0] ring;
  logic [7:0] phase;
  logic [7:0] remaining;

  johnson_phase_sched #(.WIDTH(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start), .i_rotations(rotations),
    .i_hold(hold), .i_abort(abort), .o_busy(busy), .o_done(done),
    .o_aborted(aborted), .o_ring(ring), .o_phase(phase), .o_remaining(remaining)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int         cyc;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [3:0] ring;
    logic [7:0] phase;
    logic [7:0] rem;
  } exp_t;

  exp_t  q_exp[$];
  string q_tag[$];
  int    cyc = 0;
  int    checks = 0;
  int    failures = 0;

  logic [3:0] RING_T [8] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};
  logic [7:0] PH_T   [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q_exp.size() > 0 && q_exp[0].cyc <= cyc) begin
      exp_t  e;
      string t;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", t, e.cyc, cyc);
      end else if ({busy, done, aborted, ring, phase, remaining} !==
                   {e.busy, e.done, e.aborted, e.ring, e.phase, e.rem}) begin
        failures++;
        $display("FAIL %s cyc=%0d: got busy=%b done=%b ab=%b ring=%h phase=%h rem=%0d, want busy=%b done=%b ab=%b ring=%h phase=%h rem=%0d",
                 t, cyc, busy, done, aborted, ring, phase, remaining,
                 e.busy, e.done, e.aborted, e.ring, e.phase, e.rem);
      end
    end
  end

  task automatic push_exp(input int c, input logic b, input logic d, input logic a,
                          input logic [3:0] r, input logic [7:0] ph, input logic [7:0] rm,
                          input string tag);
    exp_t e;
    e.cyc = c; e.busy = b; e.done = d; e.aborted = a; e.ring = r; e.phase = ph; e.rem = rm;
    q_exp.push_back(e);
    q_tag.push_back(tag);
  endtask

  task automatic push_idle(input int c, input string tag);
    push_exp(c, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'd0, tag);
  endtask

  // Advance to just after the next rising edge; cyc then names the current cycle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_r1(input string tag);
    int c0;
    tick();
    start = 1'b1; rotations = 8'd1; c0 = cyc;
    for (int k = 0; k < 8; k++) push_exp(c0 + 1 + k, 1'b1, 1'b0, 1'b0, RING_T[k], PH_T[k], 8'd1, tag);
    push_exp(c0 + 9, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'd0, tag);
    push_idle(c0 + 10, tag);
    tick();
    start = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    int c0;
    int k;
    // Reset held: start pulses must be ignored.
    for (int i = 0; i < 3; i++) begin
      tick();
      start = ~start; rotations = 8'd3;
      push_idle(cyc, "reset_start_ignored");
    end
    tick();
    reset = 1'b0; start = 1'b0;
    push_idle(cyc, "reset_release");
    for (int i = 0; i < 5; i++) begin
      tick();
      push_idle(cyc, "idle_after_reset");
    end

    run_r1("r1");

    // R=0: straight to DONE, busy never rises.
    tick();
    start = 1'b1; rotations = 8'd0; c0 = cyc;
    push_exp(c0 + 1, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'd0, "r0_done");
    push_idle(c0 + 2, "r0_idle");
    tick();
    start = 1'b0;
    repeat (3) tick();

    // R=2 with 3 held cycles at ring=0111 in the first revolution: 19 busy cycles.
    tick();
    start = 1'b1; rotations = 8'd2; c0 = cyc;
    for (int i = 0; i < 19; i++) begin
      k = (i <= 3) ? i : ((i <= 6) ? 3 : (i - 3) % 8);
      push_exp(c0 + 1 + i, 1'b1, 1'b0, 1'b0, RING_T[k], PH_T[k], (i <= 10) ? 8'd2 : 8'd1, "r2_hold");
    end
    push_exp(c0 + 20, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'd0, "r2_done");
    push_idle(c0 + 21, "r2_idle");
    tick(); start = 1'b0;
    repeat (3) tick(); hold = 1'b1;
    repeat (3) tick(); hold = 1'b0;
    repeat (15) tick();

    // R=5, start pulsed mid-run, abort (with hold) at ring=1100 in revolution 2.
    tick();
    start = 1'b1; rotations = 8'd5; c0 = cyc;
    for (int i = 0; i < 15; i++)
      push_exp(c0 + 1 + i, 1'b1, 1'b0, 1'b0, RING_T[i % 8], PH_T[i % 8], 8'(5 - i / 8), "r5_run");
    push_exp(c0 + 16, 1'b0, 1'b0, 1'b1, 4'h0, 8'h00, 8'd0, "r5_aborted");
    push_idle(c0 + 17, "r5_after_abort");
    push_idle(c0 + 18, "r5_no_done");
    tick(); start = 1'b0;
    repeat (4) tick(); start = 1'b1; rotations = 8'd3;
    tick(); start = 1'b0;
    repeat (9) tick(); abort = 1'b1; hold = 1'b1;
    tick(); abort = 1'b0; hold = 1'b0;
    repeat (3) tick();

    // R=255 (full scale count), async reset in cycle 100 of the run.
    tick();
    start = 1'b1; rotations = 8'd255; c0 = cyc;
    for (int i = 0; i < 99; i++)
      push_exp(c0 + 1 + i, 1'b1, 1'b0, 1'b0, RING_T[i % 8], PH_T[i % 8], 8'(255 - i / 8), "r255_run");
    push_idle(c0 + 100, "r255_async_reset");
    push_idle(c0 + 101, "r255_reset_held");
    push_idle(c0 + 102, "r255_reset_release");
    tick(); start = 1'b0;
    repeat (98) tick();
    tick(); #1 reset = 1'b1;
    tick(); reset = 1'b0;
    tick();

    run_r1("r1_after_reset");

    // start held high: back-to-back runs with one IDLE cycle between.
    tick();
    start = 1'b1; rotations = 8'd1; c0 = cyc;
    for (int k2 = 0; k2 < 8; k2++) begin
      push_exp(c0 + 1 + k2, 1'b1, 1'b0, 1'b0, RING_T[k2], PH_T[k2], 8'd1, "b2b_run1");
    end
    push_exp(c0 + 9, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'd0, "b2b_done1");
    push_idle(c0 + 10, "b2b_gap");
    for (int k2 = 0; k2 < 8; k2++) begin
      push_exp(c0 + 11 + k2, 1'b1, 1'b0, 1'b0, RING_T[k2], PH_T[k2], 8'd1, "b2b_run2");
    end
    push_exp(c0 + 19, 1'b0, 1'b1, 1'b0, 4'h0, 8'h00, 8'd0, "b2b_done2");
    push_idle(c0 + 20, "b2b_idle");
    repeat (11) tick(); start = 1'b0;
    repeat (10) tick();

    repeat (2) tick();
    checks++;
    if (q_exp.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q_exp.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
